// File: rtl/microcode_sequencer_if.sv
// Bundle of the sequencer's run/flag inputs, program-memory bus and
// register-file control outputs. The sequencer is the master: it addresses
// program memory and drives the register-file controls.
interface microcode_sequencer_if;
  logic       run;
  logic       zflag;
  logic [7:0] prog_data;
  logic [3:0] prog_addr;
  logic [3:0] instr;
  logic [3:0] imm;
  logic       busy;
  logic       halt;

  modport master (
    input  run,
    input  zflag,
    input  prog_data,
    output prog_addr,
    output instr,
    output imm,
    output busy,
    output halt
  );

  modport slave (
    output run,
    output zflag,
    output prog_data,
    input  prog_addr,
    input  instr,
    input  imm,
    input  busy,
    input  halt
  );
endinterface

// File: rtl/microcode_sequencer.sv
// Microcode sequencer for the 4-bit processor: fetches 8-bit macro
// instructions, expands each into 1..3 micro-ops for the register file,
// and owns the PC, jumps and halt.
module microcode_sequencer (
  input  logic                  clk,
  input  logic                  grst,
  microcode_sequencer_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_LDB  = 4'h2;
  localparam logic [3:0] OP_LOP  = 4'h3;
  localparam logic [3:0] OP_SHOW = 4'h4;
  localparam logic [3:0] OP_CLR  = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_JZ   = 4'h7;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [3:0] UOP_NOP    = 4'd0;
  localparam logic [3:0] UOP_WR_A   = 4'd1;
  localparam logic [3:0] UOP_WR_B   = 4'd2;
  localparam logic [3:0] UOP_WR_OP  = 4'd3;
  localparam logic [3:0] UOP_DRV_A  = 4'd4;
  localparam logic [3:0] UOP_DRV_B  = 4'd5;
  localparam logic [3:0] UOP_DRV_OP = 4'd6;
  localparam logic [3:0] UOP_CLR    = 4'd7;

  logic [1:0] state;
  logic [3:0] pc;
  logic [7:0] ir;
  logic [1:0] step;

  logic [3:0] opcode;
  logic [3:0] operand;
  logic       last_step;

  assign opcode  = ir[7:4];
  assign operand = ir[3:0];

  // SHOW is the only three-step instruction; everything else finishes in step 0.
  assign last_step = (opcode == OP_SHOW) ? (step == 2'd2) : 1'b1;

  // Sequencer state, PC, IR and step counter; grst abandons any sequence in flight.
  always_ff @(posedge clk) begin
    if (grst) begin
      state <= S_IDLE;
      pc    <= 4'd0;
      ir    <= 8'd0;
      step  <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.run) state <= S_FETCH;
        end
        S_FETCH: begin
          ir    <= bus.prog_data;
          step  <= 2'd0;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (!last_step) begin
            step <= step + 2'd1;
          end else begin
            state <= S_FETCH;
            case (opcode)
              OP_JMP:  pc <= operand;
              OP_JZ:   pc <= bus.zflag ? operand : pc + 4'd1;
              OP_HLT:  state <= S_HALT;
              default: pc <= pc + 4'd1;
            endcase
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end

  // Micro-op and immediate decode from registered IR/step/state only.
  always_comb begin
    bus.instr = UOP_NOP;
    bus.imm   = 4'd0;
    if (state == S_EXEC) begin
      case (opcode)
        OP_LDA: begin bus.instr = UOP_WR_A;  bus.imm = operand; end
        OP_LDB: begin bus.instr = UOP_WR_B;  bus.imm = operand; end
        OP_LOP: begin bus.instr = UOP_WR_OP; bus.imm = operand; end
        OP_SHOW: begin
          case (step)
            2'd0:    bus.instr = UOP_DRV_A;
            2'd1:    bus.instr = UOP_DRV_B;
            2'd2:    bus.instr = UOP_DRV_OP;
            default: bus.instr = UOP_NOP;
          endcase
        end
        OP_CLR:  bus.instr = UOP_CLR;
        default: bus.instr = UOP_NOP;
      endcase
    end
  end

  // Status and program-memory address.
  always_comb begin
    bus.prog_addr = pc;
    bus.busy      = (state == S_FETCH) || (state == S_EXEC);
    bus.halt      = (state == S_HALT);
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Testbench for microcode_sequencer: directed scenarios with literal
// expectations, then randomized programs and inputs checked every cycle
// against an instruction-level reference model.
module tb_microcode_sequencer;

  logic clk = 1'b0;
  logic grst;

  microcode_sequencer_if bus();

  logic [7:0] mem [16];

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Reference model: machine mode, PC, the word being executed, and the
  // cycle number inside the current instruction (0 = fetch cycle).
  int         m_mode;   // 0 idle, 1 running, 2 halted
  logic [3:0] m_pc;
  logic [7:0] m_word;
  int         m_cyc;

  microcode_sequencer dut (
    .clk  (clk),
    .grst (grst),
    .bus  (bus)
  );

  assign bus.prog_data = mem[bus.prog_addr];

  always #5 clk = ~clk;

  // Number of execute cycles a macro opcode takes.
  function automatic int cost(input logic [3:0] op);
    return (op == 4'h4) ? 3 : 1;
  endfunction

  // Micro-op produced in execute cycle n (1-based) of opcode op.
  function automatic logic [3:0] uop(input logic [3:0] op, input int n);
    case (op)
      4'h1, 4'h2, 4'h3: return op;
      4'h4:             return 4'(3 + n);
      4'h5:             return 4'd7;
      default:          return 4'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit z, input bit g);
    if (g) begin
      m_mode = 0; m_pc = 4'd0; m_word = 8'd0; m_cyc = 0;
    end else if (m_mode == 0) begin
      if (r) begin m_mode = 1; m_cyc = 0; end
    end else if (m_mode == 1) begin
      if (m_cyc == 0) begin
        m_word = mem[m_pc];
        m_cyc  = 1;
      end else if (m_cyc < cost(m_word[7:4])) begin
        m_cyc++;
      end else begin
        m_cyc = 0;
        case (m_word[7:4])
          4'h6:    m_pc = m_word[3:0];
          4'h7:    m_pc = z ? m_word[3:0] : m_pc + 4'd1;
          4'hF:    m_mode = 2;
          default: m_pc = m_pc + 4'd1;
        endcase
      end
    end
  endtask

  // Apply inputs, take one clock edge, advance the model with the same inputs.
  task automatic cycle(input bit r, input bit z, input bit g);
    grst     = g;
    bus.run  = r;
    bus.zflag = z;
    @(posedge clk);
    model_step(r, z, g);
    #1;
  endtask

  task automatic do_reset(input bit r);
    cycle(r, 1'b0, 1'b1);
    chk_en = 1'b1;
    cycle(r, 1'b0, 1'b1);
  endtask

  // Every cycle: DUT outputs against the reference model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0] e_instr, e_imm;
      e_instr = 4'd0;
      e_imm   = 4'd0;
      if (m_mode == 1 && m_cyc > 0) begin
        e_instr = uop(m_word[7:4], m_cyc);
        if (m_word[7:4] inside {4'h1, 4'h2, 4'h3}) e_imm = m_word[3:0];
      end
      chk("m_prog_addr", {4'd0, bus.prog_addr}, {4'd0, m_pc});
      chk("m_instr",     {4'd0, bus.instr},     {4'd0, e_instr});
      chk("m_imm",       {4'd0, bus.imm},       {4'd0, e_imm});
      chk("m_busy",      {7'd0, bus.busy},      {7'd0, m_mode == 1});
      chk("m_halt",      {7'd0, bus.halt},      {7'd0, m_mode == 2});
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    m_mode = 0; m_pc = 4'd0; m_word = 8'd0; m_cyc = 0;

    // Reset with run held high, then release.
    do_reset(1'b1);
    chk("rst_addr",  {4'd0, bus.prog_addr}, 8'd0);
    chk("rst_instr", {4'd0, bus.instr}, 8'd0);
    chk("rst_imm",   {4'd0, bus.imm}, 8'd0);
    chk("rst_busy",  {7'd0, bus.busy}, 8'd0);
    chk("rst_halt",  {7'd0, bus.halt}, 8'd0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("rel_busy",  {7'd0, bus.busy}, 8'd1);
    chk("rel_addr",  {4'd0, bus.prog_addr}, 8'd0);

    // LDA 9.
    mem[0] = 8'h19;
    do_reset(1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("lda_fetch_instr", {4'd0, bus.instr}, 8'd0);
    chk("lda_fetch_busy",  {7'd0, bus.busy}, 8'd1);
    cycle(1'b0, 1'b0, 1'b0);
    chk("lda_instr", {4'd0, bus.instr}, 8'd1);
    chk("lda_imm",   {4'd0, bus.imm}, 8'd9);
    cycle(1'b0, 1'b0, 1'b0);
    chk("lda_next_addr", {4'd0, bus.prog_addr}, 8'd1);
    chk("lda_next_instr", {4'd0, bus.instr}, 8'd0);

    // SHOW.
    mem[0] = 8'h40;
    do_reset(1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("show_c0", {4'd0, bus.instr}, 8'd0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("show_c1", {4'd0, bus.instr}, 8'd4);
    cycle(1'b0, 1'b0, 1'b0);
    chk("show_c2", {4'd0, bus.instr}, 8'd5);
    chk("show_c2_addr", {4'd0, bus.prog_addr}, 8'd0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("show_c3", {4'd0, bus.instr}, 8'd6);
    chk("show_c3_imm", {4'd0, bus.imm}, 8'd0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("show_next_addr", {4'd0, bus.prog_addr}, 8'd1);

    // JZ A, taken then not taken.
    mem[0] = 8'h7A;
    do_reset(1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    chk("jz_taken_addr", {4'd0, bus.prog_addr}, 8'hA);
    do_reset(1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("jz_not_taken_addr", {4'd0, bus.prog_addr}, 8'h1);

    // JMP 15, PC wrap to 0, then HLT.
    mem[0]  = 8'h6F;
    mem[15] = 8'h00;
    do_reset(1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("jmp_addr", {4'd0, bus.prog_addr}, 8'hF);
    mem[0] = 8'hF0;
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("wrap_addr", {4'd0, bus.prog_addr}, 8'h0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("hlt_exec_busy", {7'd0, bus.busy}, 8'd1);
    cycle(1'b0, 1'b0, 1'b0);
    chk("halt_flag", {7'd0, bus.halt}, 8'd1);
    chk("halt_busy", {7'd0, bus.busy}, 8'd0);
    chk("halt_addr", {4'd0, bus.prog_addr}, 8'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      chk("halt_run_ignored", {7'd0, bus.halt}, 8'd1);
    end

    // Reset during SHOW step 1.
    mem[0] = 8'h40;
    do_reset(1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("mid_instr_before", {4'd0, bus.instr}, 8'd5);
    cycle(1'b0, 1'b0, 1'b1);
    chk("mid_instr_after", {4'd0, bus.instr}, 8'd0);
    chk("mid_busy_after",  {7'd0, bus.busy}, 8'd0);
    chk("mid_addr_after",  {4'd0, bus.prog_addr}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      chk("mid_no_drv_op", {4'd0, bus.instr}, 8'd0);
    end

    // Randomized programs, run/zflag and occasional resets.
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    do_reset(1'b0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) mem[$urandom_range(0, 15)] = 8'($urandom);
      cycle(1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom_range(0, 39) == 0));
    end

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/microcode_sequencer.md
# microcode_sequencer

Control-store sequencer that sits directly upstream of the register file in the 4-bit microcoded processor. It fetches 8-bit macro-instructions from program memory and expands each one into a sequence of one to three 4-bit micro-ops on `instr`, with the matching immediate on `imm`. It also owns the program counter, the unconditional and zero-conditional jumps, and halt.

## Interface
- No parameters. Widths are fixed: 4-bit data, 4-bit PC, 8-bit program word.
- `clk` input 1: single system clock; all state updates on the rising edge.
- `grst` input 1: global reset; synchronous, active-high.
- `run` input 1: start request, sampled only in IDLE.
- `zflag` input 1: ALU zero flag, sampled only on the JZ execute edge.
- `prog_data` input 8: program word, `[7:4]` opcode and `[3:0]` operand. Combinational memory, valid in the same cycle as `prog_addr`.
- `prog_addr` output 4: equals PC.
- `instr` output 4: micro-op to the register file.
- `imm` output 4: immediate to the register file.
- `busy` output 1: high in FETCH and EXEC.
- `halt` output 1: high in HALT.

## Operation
- Registered state:
  - FSM state: IDLE, FETCH, EXEC or HALT.
  - PC, 4 bits.
  - IR, 8 bits.
  - `step` counter, 2 bits.
- Micro-op codes on `instr`:
  - 0 NOP
  - 1 write A from `imm`
  - 2 write B from `imm`
  - 3 write OP from `imm`
  - 4 drive A onto bus
  - 5 drive B onto bus
  - 6 drive OP onto bus
  - 7 local clear
- Macro opcodes, with the micro-op emitted at each EXEC step:
  - 0 NOP: step 0 = 0.
  - 1 LDA k: step 0 = 1.
  - 2 LDB k: step 0 = 2.
  - 3 LOP k: step 0 = 3.
  - 4 SHOW: steps 0/1/2 = 4/5/6.
  - 5 CLR: step 0 = 7.
  - 6 JMP k: step 0 = 0; PC <= k.
  - 7 JZ k: step 0 = 0; PC <= k if `zflag`=1, else PC+1.
  - F HLT: step 0 = 0; then enter HALT.
  - 8..E: executed as NOP.
- FSM transitions:
  - IDLE: `run`=1 -> FETCH; otherwise stay.
  - FETCH: IR <= `prog_data`, `step` <= 0 -> EXEC.
  - EXEC, not the last step: `step` <= `step`+1.
  - EXEC, last step: update PC -> FETCH. PC <= PC+1 unless the opcode is JMP or JZ. HLT is the exception: PC is held and the next state is HALT.
  - HALT: stays until `grst`; `run` is ignored.
- `instr` and `imm` outputs:
  - `instr` is decoded only from registered IR/`step`/state.
  - No combinational path from `prog_data` or `zflag` to `instr`/`imm`.
  - `instr` = 0 in IDLE, FETCH and HALT.
- `imm`:
  - EXEC: `imm` = IR[3:0] for opcodes 1/2/3; otherwise 0.
  - All other states: `imm` = 0.
- Arithmetic: PC+1 is modulo 16, so 15 -> 0 with no flag.
- `grst` has priority over everything, in any state including mid-sequence:
  - state <= IDLE, PC <= 0, IR <= 0, `step` <= 0.
  - The micro-sequence in progress is abandoned.

## Timing
- Reset values: `prog_addr`=0, `instr`=0, `imm`=0, `busy`=0, `halt`=0.
- Instruction cost is 1 FETCH cycle plus N EXEC cycles:
  - N = 3 for SHOW.
  - N = 1 for every other opcode.
  - So SHOW takes 4 cycles; every other opcode takes 2.
- `run` sampled high at edge t gives FETCH in cycle t+1, with `prog_addr`=PC. The first micro-op appears in cycle t+2.
- `prog_addr` changes on the edge that ends the last EXEC cycle. The next FETCH therefore sees the new address.
- JZ uses the `zflag` value present at the edge ending its EXEC cycle.
- `halt` rises in the cycle after HLT's EXEC cycle. `busy` falls in the same cycle.

## Test plan
- Reset values: assert `grst` for 2 cycles with `run`=1.
  - During reset: all outputs at reset values and state stays IDLE.
  - First cycle after release: FETCH at `prog_addr`=0.
- LDA: memory[0]=8'h19, pulse `run`.
  - Cycle t+1: FETCH, `instr`=0.
  - Cycle t+2: `instr`=1, `imm`=9.
  - Cycle t+3: FETCH at `prog_addr`=1.
- SHOW: memory[0]=8'h40.
  - `instr` goes 0, 4, 5, 6 over 4 cycles with `imm`=0 throughout.
  - `prog_addr` becomes 1 after the fourth cycle.
- JZ: memory[0]=8'h7A.
  - Run with `zflag`=1: next fetch at `prog_addr`=A.
  - Rerun with `zflag`=0: next fetch at `prog_addr`=1.
- Wrap and halt: memory[15]=8'h00, memory[0]=8'hF0, start at PC=15 via JMP 15.
  - After memory[15] executes, PC wraps to 0.
  - HLT gives `halt`=1, `busy`=0, `prog_addr` held at 0.
  - Pulsing `run` afterwards has no effect.
- Reset mid-sequence: assert `grst` during SHOW `step` 1, while `instr`=5.
  - Next cycle: `instr`=0, state IDLE, `prog_addr`=0.
  - No 6 is ever emitted.
